// File: rtl/pwm_capture.sv
// pwm_capture: recovers duty level and rise-to-rise period of an incoming PWM
// waveform, and flags an input that has stopped toggling (stuck high or low).
module pwm_capture #(
  parameter int WIDTH       = 8,
  parameter int INVERT      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH:0]   period,
  output logic             level_valid,
  output logic             stuck
);

  localparam int         CW      = WIDTH + 1;
  localparam logic [CW-1:0]    CNT_MAX = {CW{1'b1}};
  localparam logic [WIDTH-1:0] LVL_MAX = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic       INV     = (INVERT != 0);

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q, p_d;
  logic                   rise, fall;

  state_t           state_q, state_d;
  logic [CW-1:0]    per_q, per_d;
  logic [CW-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0] level_d;
  logic [CW-1:0]    period_d;
  logic             stuck_d, valid_d;
  logic             timeout;
  logic [WIDTH-1:0] hi_sat;

  // Synchronizer chain plus polarity-corrected sample and its one-cycle delay.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      p_q    <= 1'b0;
      p_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      p_q    <= sync_q[SYNC_STAGES-1] ^ INV;
      p_d    <= p_q;
    end
  end

  assign rise    = p_q & ~p_d;
  assign fall    = ~p_q & p_d;
  assign timeout = (per_q == CNT_MAX);
  // Publishing a long high interval clamps to full scale rather than wrapping.
  assign hi_sat  = (hi_q > CW'(LVL_MAX)) ? LVL_MAX : hi_q[WIDTH-1:0];

  // Next-state, counter and publish logic.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    per_d    = timeout ? per_q : per_q + CNT_ONE;
    hi_d     = hi_q;
    level_d  = level;
    period_d = period;
    stuck_d  = stuck;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          // First interval after reset is partial: take it as reference only.
          per_d   = CNT_ONE;
          hi_d    = CNT_ONE;
          state_d = MEASURE;
        end else if (timeout) begin
          level_d  = p_q ? LVL_MAX : '0;
          period_d = '0;
          stuck_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = STUCK;
        end
      end
      MEASURE: begin
        if (rise) begin
          level_d  = hi_sat;
          period_d = per_q;
          stuck_d  = 1'b0;
          valid_d  = 1'b1;
          per_d    = CNT_ONE;
          hi_d     = CNT_ONE;
        end else if (timeout) begin
          level_d  = p_q ? LVL_MAX : '0;
          period_d = '0;
          stuck_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = STUCK;
        end else if (hi_q != CNT_MAX) begin
          hi_d = hi_q + CW'(p_q);
        end
      end
      STUCK: begin
        per_d = per_q;
        if (rise) begin
          // Stuck stays reported until the next full period is published.
          per_d   = CNT_ONE;
          hi_d    = CNT_ONE;
          state_d = MEASURE;
        end else if (fall) begin
          level_d  = '0;
          period_d = '0;
          stuck_d  = 1'b1;
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      per_q       <= '0;
      hi_q        <= '0;
      level       <= '0;
      period      <= '0;
      stuck       <= 1'b0;
      level_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      hi_q        <= hi_d;
      level       <= level_d;
      period      <= period_d;
      stuck       <= stuck_d;
      level_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives one logical PWM waveform into a non-inverting capture
// and (inverted) into an inverting capture, and checks both against
// hand-computed duty/period values.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw = 1'b0;
  logic       pwm0, pwm1;
  logic [7:0] level0, level1;
  logic [8:0] period0, period1;
  logic       valid0, valid1, stuck0, stuck1;

  assign pwm0 = raw;
  assign pwm1 = ~raw;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(8), .INVERT(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .pwm_in(pwm0), .level(level0),
    .period(period0), .level_valid(valid0), .stuck(stuck0));

  pwm_capture #(.WIDTH(8), .INVERT(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .pwm_in(pwm1), .level(level1),
    .period(period1), .level_valid(valid1), .stuck(stuck1));

  typedef struct {
    int cyc;
    int lvl;
    int per;
    int stk;
  } strobe_t;

  typedef struct {
    int high;
    int per;
    int exp_level;
    int exp_period;
  } vec_t;

  strobe_t q0[$];
  strobe_t q1[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  logic    prev0 = 1'b0, prev1 = 1'b0;
  int      b2b0 = 0, b2b1 = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock: sample registered outputs 1ns after the edge and log strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid0) q0.push_back('{cyc, int'(level0), int'(period0), int'(stuck0)});
    if (valid1) q1.push_back('{cyc, int'(level1), int'(period1), int'(stuck1)});
    if (valid0 && prev0) b2b0++;
    if (valid1 && prev1) b2b1++;
    prev0 = valid0;
    prev1 = valid1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw   = 1'b0;
    repeat (3) tick();
    check("reset_level0",  int'(level0),  0);
    check("reset_period0", int'(period0), 0);
    check("reset_stuck1",  int'(stuck1),  0);
    check("reset_valid1",  int'(valid1),  0);
    reset = 1'b0;
    cyc = 0;
    q0.delete();
    q1.delete();
  endtask

  task automatic run_wave(input int high, input int per, input int n);
    for (int k = 0; k < n; k++)
      for (int ph = 0; ph < per; ph++) begin
        raw = (ph < high);
        tick();
      end
  endtask

  vec_t vecs[7];
  int   n0;

  initial begin
    vecs[0] = '{64, 256, 64, 256};
    vecs[1] = '{1, 256, 1, 256};
    vecs[2] = '{128, 256, 128, 256};
    vecs[3] = '{255, 256, 255, 256};
    vecs[4] = '{300, 400, 255, 400};
    vecs[5] = '{1, 2, 1, 2};
    vecs[6] = '{5, 10, 5, 10};

    // Steady-state waveforms: six periods, first strobe may be partial.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      b2b0 = 0;
      b2b1 = 0;
      run_wave(vecs[i].high, vecs[i].per, 6);
      raw = 1'b0;
      repeat (8) tick();
      check($sformatf("v%0d_count0", i), q0.size(), 5);
      check($sformatf("v%0d_b2b", i), b2b0 + b2b1, 0);
      for (int k = 1; k < q0.size(); k++) begin
        check($sformatf("v%0d_lvl0_%0d", i, k), q0[k].lvl, vecs[i].exp_level);
        check($sformatf("v%0d_per0_%0d", i, k), q0[k].per, vecs[i].exp_period);
        check($sformatf("v%0d_stk0_%0d", i, k), q0[k].stk, 0);
        check($sformatf("v%0d_gap0_%0d", i, k), q0[k].cyc - q0[k-1].cyc,
              vecs[i].exp_period);
      end
      for (int k = 1; k < q1.size(); k++) begin
        check($sformatf("v%0d_lvl1_%0d", i, k), q1[k].lvl, vecs[i].exp_level);
        check($sformatf("v%0d_per1_%0d", i, k), q1[k].per, vecs[i].exp_period);
      end
    end

    // Latency: rise applied before edge E gives a strobe seen after edge E+3.
    do_reset();
    repeat (5) begin raw = 1'b1; tick(); end
    repeat (5) begin raw = 1'b0; tick(); end
    raw = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check($sformatf("lat_valid0_t%0d", t), int'(valid0), (t == 4) ? 1 : 0);
      check($sformatf("lat_valid1_t%0d", t), int'(valid1), (t == 4) ? 1 : 0);
    end
    check("lat_level0",  int'(level0),  5);
    check("lat_period0", int'(period0), 10);

    // Constant low after reset: one timeout strobe, then silence.
    do_reset();
    raw = 1'b0;
    repeat (1100) tick();
    check("low_count0", q0.size(), 1);
    if (q0.size() > 0) begin
      check("low_cyc0",    q0[0].cyc, 512);
      check("low_level0",  q0[0].lvl, 0);
      check("low_period0", q0[0].per, 0);
      check("low_stuck0",  q0[0].stk, 1);
    end

    // Held high after activity, then low, then resumed 50% PWM.
    do_reset();
    run_wave(128, 256, 3);
    q0.delete();
    q1.delete();
    raw = 1'b1;
    repeat (600) tick();
    n0 = q0.size();
    check("hold_count0", n0, 2);
    if (n0 > 0) begin
      check("hold_level0",  q0[n0-1].lvl, 255);
      check("hold_period0", q0[n0-1].per, 0);
      check("hold_stuck0",  q0[n0-1].stk, 1);
    end
    check("hold_level1", int'(level1), 255);
    check("hold_stuck1", int'(stuck1), 1);
    q0.delete();
    raw = 1'b0;
    repeat (20) tick();
    check("drop_count0", q0.size(), 1);
    check("drop_level0", int'(level0), 0);
    check("drop_stuck0", int'(stuck0), 1);
    q0.delete();
    for (int ph = 0; ph < 200; ph++) begin raw = (ph < 128); tick(); end
    check("resume1_count0", q0.size(), 0);
    check("resume1_stuck0", int'(stuck0), 1);
    for (int ph = 200; ph < 256 + 10; ph++) begin raw = ((ph % 256) < 128); tick(); end
    check("resume2_count0",  q0.size(), 1);
    check("resume2_stuck0",  int'(stuck0), 0);
    check("resume2_level0",  int'(level0), 128);
    check("resume2_period0", int'(period0), 256);
    check("resume2_level1",  int'(level1), 128);
    check("resume2_stuck1",  int'(stuck1), 0);

    // Reset mid-period clears outputs at once without a strobe.
    do_reset();
    for (int ph = 0; ph < 300; ph++) begin raw = ((ph % 256) < 64); tick(); end
    check("mid_level_before", int'(level0), 64);
    n0 = q0.size();
    reset = 1'b1;
    tick();
    check("mid_level0",  int'(level0),  0);
    check("mid_period0", int'(period0), 0);
    check("mid_valid0",  int'(valid0),  0);
    check("mid_level1",  int'(level1),  0);
    check("mid_nostrobe", q0.size(), n0);
    reset = 1'b0;

    // Falling-edge jitter of +/-1 cycle: level stays within 1 of nominal.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      int h;
      h = 127 + int'($urandom_range(0, 2));
      for (int ph = 0; ph < 256; ph++) begin raw = (ph < h); tick(); end
    end
    raw = 1'b0;
    repeat (8) tick();
    check("jit_count0", q0.size(), 5);
    for (int k = 1; k < q0.size(); k++) begin
      check($sformatf("jit_lvl_ok_%0d", k),
            int'(q0[k].lvl >= 127 && q0[k].lvl <= 129), 1);
      check($sformatf("jit_per_%0d", k), q0[k].per, 256);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and recovers its duty level and period. It is the receive-side counterpart of the team's counter-compare PWM generator: fed from a generator of the same `WIDTH` and `INVERT`, it returns the `level` that generator was driven with. It reports the period between rising edges and flags a stuck (constant) input. It sits behind an input pad, for example a loopback check or a servo/LED feedback path.

## Interface
- `WIDTH`, 8: level width; nominal PWM period is 2^WIDTH cycles.
- `INVERT`, 0: 1 = input is active-low (inverted before measurement).
- `SYNC_STAGES`, 2: synchronizer flops on `pwm_in` (≥2).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `pwm_in`  in  1  asynchronous PWM input.
- `level`  out  WIDTH  measured high-cycle count of last complete period, saturated to 2^WIDTH−1.
- `period`  out  WIDTH+1  cycles between last two rising edges; 0 when stuck.
- `level_valid`  out  1  one-cycle strobe: `level`/`period`/`stuck` just updated.
- `stuck`  out  1  no rising edge seen within timeout; input constant.

## Operation
- Input path: `SYNC_STAGES` flops (reset 0), then `p = sync_out ^ INVERT`; `p_d` = `p` delayed one cycle (reset 0). `rise = p & ~p_d`; `fall = ~p & p_d`.
- Counters `per_cnt`, `hi_cnt`: WIDTH+1 bits, saturating at MAX = 2^(WIDTH+1)−1, never wrap.
- States:
  - IDLE: after reset; no reference edge yet.
  - MEASURE: counting from last rise.
  - STUCK: timeout reported; waiting for activity.
- IDLE:
  - `per_cnt` increments each cycle.
  - On `rise`: `per_cnt<=1`, `hi_cnt<=1`, go to MEASURE. No publish, because the first interval is partial.
  - If `per_cnt==MAX` without `rise`: timeout.
- MEASURE, non-rise cycles: `per_cnt+=1`; `hi_cnt+=p`.
- MEASURE, on `rise`:
  - Publish `period<=per_cnt`, `level<=min(hi_cnt, 2^WIDTH−1)`, `stuck<=0`, strobe.
  - Reload `per_cnt<=1`, `hi_cnt<=1`.
  - Result: `period` = cycles from rise to rise; `level` = high cycles in that interval.
- Timeout in IDLE or MEASURE (`per_cnt==MAX`, no `rise` this cycle):
  - Publish `level <= p ? 2^WIDTH−1 : 0`, `period<=0`, `stuck<=1`, strobe.
  - Go to STUCK.
- STUCK:
  - On `rise`: `per_cnt<=1`, `hi_cnt<=1`, go to MEASURE. `stuck` stays 1 until the next publish.
  - On `fall`: publish `level<=0`, `period<=0`, `stuck<=1`, strobe; stay in STUCK.
- Simultaneous timeout and `rise` in the same cycle: `rise` wins (normal MEASURE publish).
- `rise` always takes precedence over counter saturation.
- Publishing `level` with `hi_cnt` > 2^WIDTH−1 saturates; it never truncates.
- Reset mid-measurement: all state and outputs return to reset values immediately. The synchronizer is cleared and no strobe is generated.

## Timing
- Reset values: `level`=0, `period`=0, `level_valid`=0, `stuck`=0, state IDLE, counters 0.
- All outputs are registered. `level`/`period`/`stuck` change only in the cycle `level_valid`=1 and hold otherwise.
- Latency: a rising edge on `pwm_in`, first sampled at edge E, produces `level_valid`=1 in the cycle after edge E+SYNC_STAGES+1 (SYNC_STAGES+2 edges total).
- First publish after reset requires two rising edges of `p`.
- Timeout: a stuck report occurs MAX cycles after the last reference point (reset or last rise). With WIDTH=8 that is 511 cycles, about 2× the nominal period.
- `level_valid` is never high for two consecutive cycles.
- Minimum measurable period: 2 cycles.

## Test plan
- Generator loopback, WIDTH=8, INVERT=0, level=64, free-running:
  - From the second publish on, each strobe gives `level`=64, `period`=256, `stuck`=0.
  - Exactly one strobe per 256 cycles.
- Sweep level 1, 128, 255, with INVERT=1 on both generator and capture: `level` equals the programmed value; `period`=256 every strobe.
- Level 0 (input constant low) after reset: single strobe at timeout with `level`=0, `period`=0, `stuck`=1; no further strobes while low.
- Input held high for 600 cycles after activity:
  - Strobe with `level`=255, `stuck`=1.
  - Then drop low: strobe `level`=0.
  - Then resume 50% 256-cycle PWM: `stuck` clears at the second rise with `level`=128.
- Stretched period of 400 cycles, high 300: `period`=400, `level`=255 (saturated).
- Reset asserted mid-period: outputs 0 next cycle, no strobe.
- Asynchronous `pwm_in` jitter of ±1 cycle on edges: `level` is within ±1 of nominal.
